// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-precision adder that reuses one 4-bit ripple
// slice over WIDTH/4 cycles, chaining the carry through c_r between nibbles.
// Optional feature macro: SUBTRACT_EN (enables a-b via the sub input).
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands a/b/sub valid          in_ready  accepting (IDLE only)
//   a, b       WIDTH-bit operands              sub       1 = a-b (SUBTRACT_EN)
//   out_valid  sum/cout hold a result          out_ready consumer accepts
//   sum        registered WIDTH-bit result     cout      carry out of top nibble
//   busy       operation in progress (RUN or DONE)
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned IDX_W   = CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] cnt;
  logic             c_r;

  logic             accept;
  logic             last;
  logic [IDX_W-1:0] base;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       s4;
  logic             c_next;
  logic [WIDTH-1:0] b_load;
  logic             c_init;

  // Operand conditioning at the handshake: subtraction is a + ~b + 1
`ifdef SUBTRACT_EN
  assign b_load = sub ? ~b : b;
  assign c_init = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = b;
  assign c_init     = 1'b0;
`endif

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CNT_W'(NIBBLES - 1));
  assign base   = {cnt, 2'b00};
  assign nib_a  = a_r[base +: 4];
  assign nib_b  = b_r[base +: 4];

  // 4-bit ripple full-adder slice shared by all nibbles
  always_comb begin
    logic carry;
    s4    = '0;
    carry = c_r;
    for (int i = 0; i < 4; i++) begin
      s4[i] = nib_a[i] ^ nib_b[i] ^ carry;
      carry = (nib_a[i] & nib_b[i]) | (carry & (nib_a[i] ^ nib_b[i]));
    end
    c_next = carry;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand latch, nibble counter, carry chain register, result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      cnt  <= '0;
      c_r  <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_r  <= a;
      b_r  <= b_load;
      cnt  <= '0;
      c_r  <= c_init;
      sum  <= '0;
    end else if (state == RUN) begin
      sum[base +: 4] <= s4;
      c_r            <= c_next;
      cnt            <= cnt + CNT_W'(1);
      // Top carry goes to cout only; it is never folded into sum
      if (last) cout <= c_next;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector
// table, hand-written reset/subtract sequences, and random operations checked
// against an arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    int               hold;
    bit               noise;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [WIDTH-1:0] act,
                          input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: {cout, sum} from plain integer arithmetic
  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic s);
    logic [WIDTH:0] r;
    logic unused_s;
    unused_s = s;
    r = {1'b0, x} + {1'b0, y};
`ifdef SUBTRACT_EN
    if (s) r = {(x >= y), WIDTH'(x - y)};
`endif
    return r;
  endfunction

  // One full operation starting at a negedge in IDLE; checks latency,
  // result, backpressure stability, busy duration and return to IDLE.
  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xs, input logic [WIDTH-1:0] es,
                        input logic ec, input int hold, input bit noise,
                        input string tag);
    int n;
    int busy_n;
    chk_bit({tag, "_in_ready_idle"}, in_ready, 1'b1);
    a         = xa;
    b         = xb;
    sub       = xs;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    chk_bit({tag, "_busy_after_accept"}, busy, 1'b1);
    chk_bit({tag, "_in_ready_run"}, in_ready, 1'b0);
    if (noise) begin
      a        = 16'h0F0F;
      b        = 16'h0101;
      sub      = ~xs;
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
    end
    n      = 0;
    busy_n = 1;
    while (!out_valid && n < 4 * NIBBLES + 4) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
    end
    chk_int({tag, "_latency"}, n, NIBBLES);
    chk_word({tag, "_sum"}, sum, es);
    chk_bit({tag, "_cout"}, cout, ec);
    chk_bit({tag, "_in_ready_done"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      chk_bit({tag, "_hold_valid"}, out_valid, 1'b1);
      chk_word({tag, "_hold_sum"}, sum, es);
      chk_bit({tag, "_hold_cout"}, cout, ec);
      chk_bit({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_int({tag, "_busy_cycles"}, busy_n, NIBBLES + 1 + hold);
    chk_bit({tag, "_valid_drop"}, out_valid, 1'b0);
    chk_bit({tag, "_in_ready_back"}, in_ready, 1'b1);
    chk_bit({tag, "_busy_drop"}, busy, 1'b0);
    chk_word({tag, "_sum_retained"}, sum, es);
    chk_bit({tag, "_cout_retained"}, cout, ec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rs;

    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, s: 16'h0000, c: 1'b1, hold: 0, noise: 1'b0};
    vecs[1] = '{a: 16'h1234, b: 16'h4321, s: 16'h5555, c: 1'b0, hold: 0, noise: 1'b0};
    vecs[2] = '{a: 16'h0FFF, b: 16'h0001, s: 16'h1000, c: 1'b0, hold: 6, noise: 1'b0};
    vecs[3] = '{a: 16'h1111, b: 16'h2222, s: 16'h3333, c: 1'b0, hold: 1, noise: 1'b1};
    vecs[4] = '{a: 16'h0F0F, b: 16'h0101, s: 16'h1010, c: 1'b0, hold: 0, noise: 1'b0};
    vecs[5] = '{a: 16'h8000, b: 16'h8000, s: 16'h0000, c: 1'b1, hold: 2, noise: 1'b0};
    vecs[6] = '{a: 16'hFFFF, b: 16'hFFFF, s: 16'hFFFE, c: 1'b1, hold: 0, noise: 1'b1};
    vecs[7] = '{a: 16'hF000, b: 16'h1000, s: 16'h0000, c: 1'b1, hold: 0, noise: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 16'h1234;
    b         = 16'h1111;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_bit("reset_in_ready", in_ready, 1'b1);
    chk_bit("reset_out_valid", out_valid, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_word("reset_sum", sum, '0);
    chk_bit("reset_cout", cout, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk_bit("post_reset_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, vecs[i].s, vecs[i].c, vecs[i].hold,
             vecs[i].noise, $sformatf("vec%0d", i));
    end

    // Reset during the second RUN cycle discards the operation
    a         = 16'h1111;
    b         = 16'h2222;
    sub       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk_word("midrun_nibble0", sum, 16'h0003);
    rst_n = 1'b0;
    @(negedge clk);
    chk_bit("midrun_rst_out_valid", out_valid, 1'b0);
    chk_word("midrun_rst_sum", sum, '0);
    chk_bit("midrun_rst_cout", cout, 1'b0);
    chk_bit("midrun_rst_busy", busy, 1'b0);
    chk_bit("midrun_rst_in_ready", in_ready, 1'b1);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 0, 1'b0, "after_reset");

`ifdef SUBTRACT_EN
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0, "sub_borrow");
    run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1, 1'b0, "sub_noborrow");
`else
    run_op(16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0, 0, 1'b0, "sub_ignored");
`endif

    for (int i = 0; i < 40; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rs  = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ~ra + WIDTH'(i / 8);
      exp = ref_result(ra, rb, rs);
      run_op(ra, rb, rs, exp[WIDTH-1:0], exp[WIDTH], int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
